cdb_arbiter: RTL
================

# cdb_arbiter

- Sits between the functional-unit reservation stations (add, load/store, branch) and the common data bus (CDB).
- Buffers each unit's completed result (ROB tag + value) in a small per-source queue.
- Each cycle, grants up to two queued results onto the two CDB channels in round-robin order.
- The CDB channels are consumed by the ROB and by every reservation station for operand wake-up.

## Interface

Parameters:
- NUM_SRC, 4: number of result sources (functional units).
- DEPTH, 2: entries per source queue (power of two, ≥2).
- ROB_W, 6: ROB tag width.
- DATA_W, 32: result width.
- INVALID_ROB, 6'd16: tag driven on an idle channel (ROB has 16 entries, tags 0..15).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous misprediction flush from ROB.
- src_valid  in  NUM_SRC  source i presents a result this cycle.
- src_rob  in  NUM_SRC*ROB_W  source i tag, slice [i*ROB_W +: ROB_W].
- src_data  in  NUM_SRC*DATA_W  source i value, slice [i*DATA_W +: DATA_W].
- src_ready  out  NUM_SRC  source i queue can accept (combinational from queue count).
- cdb0_valid  out  1  channel 0 broadcast.
- cdb0_rob  out  ROB_W  channel 0 tag.
- cdb0_data  out  DATA_W  channel 0 value.
- cdb1_valid, cdb1_rob, cdb1_data  out  1/ROB_W/DATA_W  channel 1, same meaning.

## Operation

- Push: at a rising edge with src_valid[i] && src_ready[i] && !flush, {src_rob, src_data} are written at the tail of queue i.
- src_ready[i] = (count[i] < DEPTH). A full queue is not ready even if it pops in the same cycle.
- src_valid while not ready: the result is not taken; the source must hold it.
- Grant: combinationally scan sources starting at rr_ptr, modulo NUM_SRC.
  - First non-empty queue goes to channel 0; next non-empty queue goes to channel 1.
  - At most one pop per queue per cycle.
- Pop: each granted queue loses its head at the edge; the head's tag/data are registered into the granted channel.
- rr_ptr: after a cycle with grants, becomes (last granted index + 1) mod NUM_SRC. Unchanged when nothing is granted.
- Idle channel (no grant): valid=0, rob=INVALID_ROB, data holds its previous value.
- Simultaneous push and pop on the same queue (non-full): both take effect, count unchanged.
- Flush: at an edge with flush=1, all queues are emptied, both valid outputs go to 0, both rob outputs go to INVALID_ROB, rr_ptr is reset to 0, and pushes that cycle are dropped. Flush has priority over push and grant.
- Duplicate tags are not checked; uniqueness is the ROB's responsibility.

## Timing

- Reset (async, immediate):
  - All counts 0, so src_ready = all 1s.
  - cdb0_valid = cdb1_valid = 0.
  - cdb0_rob = cdb1_rob = INVALID_ROB.
  - cdb0_data = cdb1_data = 0.
  - rr_ptr = 0; queue pointers 0.
- Reset mid-operation discards all queued results; there is no partial broadcast.
- Latency: a result pushed at edge k is broadcast on the CDB, at the earliest, during the cycle after edge k+1 (one queue stage plus one output register). There is no empty-queue bypass.
- Each CDB valid is a one-cycle pulse per result. Back-to-back results from one source broadcast on consecutive cycles.
- Throughput: 2 results/cycle aggregate; 1 result/cycle per source.
- Pointer wrap: head/tail are log2(DEPTH)-bit and wrap naturally; count is log2(DEPTH)+1 bits.

## Configuration

- CDB_DUAL_CHANNEL_EN defined: two channels as described.
- CDB_DUAL_CHANNEL_EN undefined:
  - Only channel 0 is granted (1 result/cycle).
  - cdb1_valid is tied to 0, cdb1_rob to INVALID_ROB, cdb1_data to 0.
  - rr_ptr advances past the single granted source.
  - The port list is unchanged.

## Test plan

- Single result: src_valid[0]=1, rob=3, data=0x11 for one cycle after reset. cdb0_valid pulses exactly once, on the second cycle after the push edge, with rob=3, data=0x11; cdb1_valid stays 0.
- Fairness: all four sources push one result in the same cycle (rob 0,1,2,3). The next broadcast cycle puts rob 0 on ch0 and rob 1 on ch1; the following cycle puts rob 2 on ch0 and rob 3 on ch1; then rr_ptr=0.
- Backpressure: hold src_valid[2] with distinct tags while sources 0, 1, 3 keep their queues non-empty. src_ready[2] drops after DEPTH=2 accepts; no tag is lost or duplicated across 10 results.
- Flush: fill all queues, then assert flush for one cycle while pushing rob=7. Next cycle: both valids are 0 and both robs equal 16; rob=7 is never broadcast; src_ready is all 1s.
- Async reset mid-burst: assert reset between edges during a broadcast. Outputs go to valid=0, rob=16, data=0 immediately, without waiting for a clock edge; after release, pushes behave as from cold start.
- Macro off: repeat the fairness test. Broadcasts are rob 0,1,2,3 on ch0 over four consecutive cycles; cdb1_valid stays 0 throughout.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result queues granted round-robin onto the common data bus.
// Define CDB_DUAL_CHANNEL_EN to enable the second CDB channel.
module cdb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DEPTH = 2,
  parameter int ROB_W = 6,
  parameter int DATA_W = 32,
  parameter logic [ROB_W-1:0] INVALID_ROB = ROB_W'(16)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*ROB_W-1:0]  src_rob,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      cdb0_valid,
  output logic [ROB_W-1:0]          cdb0_rob,
  output logic [DATA_W-1:0]         cdb0_data,
  output logic                      cdb1_valid,
  output logic [ROB_W-1:0]          cdb1_rob,
  output logic [DATA_W-1:0]         cdb1_data
);
  localparam int PW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ROB_W-1:0]  q_rob  [NUM_SRC][DEPTH];
  logic [DATA_W-1:0] q_data [NUM_SRC][DEPTH];
  logic [AW-1:0]     head   [NUM_SRC];
  logic [AW-1:0]     tail   [NUM_SRC];
  logic [CW-1:0]     count  [NUM_SRC];
  logic [PW-1:0]     rr_ptr, g0_idx, g1_idx, last_idx;
  logic              g0_hit, g1_hit;
  logic [NUM_SRC-1:0] push, pop;

  // Source index k steps after base, modulo NUM_SRC.
  function automatic logic [PW-1:0] src_at(input logic [PW-1:0] base, input int k);
    logic [PW:0] s;
    s = {1'b0, base} + (PW+1)'(k);
    return s >= (PW+1)'(NUM_SRC) ? PW'(s - (PW+1)'(NUM_SRC)) : PW'(s);
  endfunction

  always_comb begin
    g0_hit = 1'b0;
    g0_idx = '0;
    g1_hit = 1'b0;
    g1_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (count[src_at(rr_ptr, k)] != '0) begin
        if (!g0_hit) begin
          g0_hit = 1'b1;
          g0_idx = src_at(rr_ptr, k);
        end
`ifdef CDB_DUAL_CHANNEL_EN
        else if (!g1_hit) begin
          g1_hit = 1'b1;
          g1_idx = src_at(rr_ptr, k);
        end
`endif
      end
    end
  end

  assign last_idx = g1_hit ? g1_idx : g0_idx;

  // A full queue stays not-ready even when it pops this cycle.
  always_comb begin
    src_ready = '0;
    push = '0;
    pop = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = count[i] < CW'(DEPTH);
      push[i] = src_valid[i] && src_ready[i] && !flush;
      pop[i] = (g0_hit && g0_idx == PW'(i)) || (g1_hit && g1_idx == PW'(i));
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        q_rob[i][tail[i]] <= src_rob[i*ROB_W +: ROB_W];
        q_data[i][tail[i]] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
        count[i] <= '0;
      end
      rr_ptr <= '0;
      cdb0_valid <= 1'b0;
      cdb0_rob <= INVALID_ROB;
      cdb0_data <= '0;
`ifdef CDB_DUAL_CHANNEL_EN
      cdb1_valid <= 1'b0;
      cdb1_rob <= INVALID_ROB;
      cdb1_data <= '0;
`endif
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
        count[i] <= '0;
      end
      rr_ptr <= '0;
      cdb0_valid <= 1'b0;
      cdb0_rob <= INVALID_ROB;
`ifdef CDB_DUAL_CHANNEL_EN
      cdb1_valid <= 1'b0;
      cdb1_rob <= INVALID_ROB;
`endif
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) tail[i] <= tail[i] + AW'(1);
        if (pop[i]) head[i] <= head[i] + AW'(1);
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
      if (g0_hit) rr_ptr <= src_at(last_idx, 1);
      cdb0_valid <= g0_hit;
      cdb0_rob <= g0_hit ? q_rob[g0_idx][head[g0_idx]] : INVALID_ROB;
      if (g0_hit) cdb0_data <= q_data[g0_idx][head[g0_idx]];
`ifdef CDB_DUAL_CHANNEL_EN
      cdb1_valid <= g1_hit;
      cdb1_rob <= g1_hit ? q_rob[g1_idx][head[g1_idx]] : INVALID_ROB;
      if (g1_hit) cdb1_data <= q_data[g1_idx][head[g1_idx]];
`endif
    end
  end

`ifndef CDB_DUAL_CHANNEL_EN
  assign cdb1_valid = 1'b0;
  assign cdb1_rob = INVALID_ROB;
  assign cdb1_data = '0;
`endif
endmodule
